// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the 5-stage CPU pipeline controller.
package cpu_ctrl_pkg;
  localparam int REG_W = 4;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls between the datapath and the sequencer.
interface pipeline_ctrl_if
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_vld;
  logic             id_rt_vld;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             br_taken;
  logic             halt_id;
  logic             imem_stall;
  logic             dmem_stall;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_rs_vld, id_rt_vld, idex_memread, idex_rd,
           br_taken, halt_id, imem_stall, dmem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
           halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_vld, id_rt_vld, idex_memread, idex_rd,
           br_taken, halt_id, imem_stall, dmem_stall,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en,
           halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the instruction in ID needs a register a load in EX has not produced yet.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_vld,
  input  logic             id_rt_vld,
  output logic             lu
);
  // R0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = idex_memread && (idex_rd != '0) &&
              ((id_rs_vld && (id_rs == idex_rd)) || (id_rt_vld && (id_rt == idex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle advance/freeze/bubble decisions for every pipeline register,
// plus HLT drain tracking and a saturating stall counter.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int DW = (DRAIN_CYC > 4) ? $clog2(DRAIN_CYC) : 2;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  ctrl_state_t      st;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;

  hazard_detect u_hazard (
    .idex_memread (bus.idex_memread),
    .idex_rd      (bus.idex_rd),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_rs_vld    (bus.id_rs_vld),
    .id_rt_vld    (bus.id_rt_vld),
    .lu           (lu)
  );

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.memwb_en    = 1'b0;
    if (rst) begin
      case (st)
        RUN: begin
          if (bus.dmem_stall) begin
            bus.pc_en = 1'b0;
          end else if (lu) begin
            bus.idex_bubble = 1'b1;
            bus.exmem_en    = 1'b1;
            bus.memwb_en    = 1'b1;
          end else if (bus.halt_id) begin
            bus.exmem_en = 1'b1;
            bus.memwb_en = 1'b1;
          end else begin
            // A redirect outranks an imem stall: the fetch is simply re-issued at the target.
            bus.pc_en      = bus.br_taken || !bus.imem_stall;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = bus.br_taken || bus.imem_stall;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
          end
        end
        DRAIN: begin
          bus.idex_bubble = 1'b1;
          bus.exmem_en    = !bus.dmem_stall;
          bus.memwb_en    = !bus.dmem_stall;
        end
        default: bus.pc_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (st)
        RUN: begin
          if (!bus.dmem_stall && !lu && bus.halt_id) begin
            st        <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!bus.dmem_stall) begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_cnt == DRAIN_LAST) st <= HALTED;
          end
        end
        default: st <= HALTED;
      endcase
      if (!bus.pc_en && (st != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.halted    = rst && (st == HALTED);
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for the 16-bit 5-stage CPU.
- Each cycle it decides whether each pipeline register advances, freezes, or is loaded with a bubble: PC, IF/ID, ID/EX (bubble only), EX/MEM and MEM/WB.
- Covers load-use hazards, taken-branch redirects, instruction/data memory stalls and HLT drain.
- Drives the enable/flush inputs of the pipeline registers. An IF/ID flush loads NOP 16'h0800.

Parameters:
- DRAIN_CYC, 3, cycles after HLT leaves ID before the pipeline is fully drained.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs  in  4  source register A of the instruction in ID.
- id_rt  in  4  source register B of the instruction in ID.
- id_rs_vld  in  1  ID instruction reads id_rs.
- id_rt_vld  in  1  ID instruction reads id_rt.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  4  destination register of the instruction in EX.
- br_taken  in  1  branch resolved taken in ID; PC mux selects the target.
- halt_id  in  1  HLT decoded in ID.
- imem_stall  in  1  instruction memory not ready this cycle.
- dmem_stall  in  1  data memory not ready this cycle.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID enable.
- ifid_flush  out  1  load NOP into IF/ID (asserted only with ifid_en=1).
- idex_bubble  out  1  load all-zero control word into ID/EX.
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- halted  out  1  pipeline drained after HLT.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 (excluding HALTED).

Behaviour:
- Registered state: st in {RUN, DRAIN, HALTED}, drain_cnt (2 bits min, sized to DRAIN_CYC), stall_cnt.
- All outputs other than stall_cnt and halted are combinational from st and the inputs; zero latency.
- Reset (rst=0 at clock edge): st=RUN, drain_cnt=0, stall_cnt=0.
- While rst=0: all enable, flush and bubble outputs = 0, halted=0.
- Load-use (lu) = idex_memread & idex_rd!=0 & ((id_rs_vld & id_rs==idex_rd) | (id_rt_vld & id_rt==idex_rd)). R0 never causes a hazard.
- Default (RUN, no event): pc_en=ifid_en=exmem_en=memwb_en=1; ifid_flush=idex_bubble=0.
- RUN priority, highest first:
  1. dmem_stall: all enables 0, no flush/bubble; whole pipe frozen; st holds.
  2. lu: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1. Lasts exactly one cycle, since the load advances to MEM.
  3. halt_id: pc_en=0, ifid_en=0, idex_bubble=0 (HLT enters EX), exmem_en=memwb_en=1. Next st=DRAIN, drain_cnt=0.
  4. br_taken: pc_en=1, ifid_en=1, ifid_flush=1. Exactly one wrong-path slot is squashed.
  5. imem_stall: pc_en=0, ifid_en=1, ifid_flush=1 (bubble into IF/ID); downstream advances.
- br_taken and imem_stall together: br_taken wins; the redirect is taken and the fetch is re-issued at the target.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=!dmem_stall.
  - drain_cnt increments only when dmem_stall=0.
  - When drain_cnt==DRAIN_CYC-1 and dmem_stall=0: next st=HALTED.
  - br_taken, halt_id, imem_stall and lu are ignored.
- HALTED: all enables 0, halted=1. Sticky until reset.
- stall_cnt: increments when pc_en=0 and st!=HALTED; saturates at all-ones, no wrap.
- Reset asserted mid-DRAIN or mid-stall: returns to RUN with counters cleared on that edge.

Decomposition:
- Package cpu_ctrl_pkg: state enum (RUN/DRAIN/HALTED), NOP_INSTR=16'h0800, REG_W=4.
- One sub-module: hazard_detect, the combinational load-use comparator producing lu.

Test Plan:
- Reset: hold rst=0 for 2 cycles with br_taken=1 -> all enables 0, stall_cnt=0; after release, default RUN outputs.
- Load-use: idex_memread=1, idex_rd=3, id_rs=3, id_rs_vld=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt=1. Repeat with idex_rd=0 -> no stall.
- Branch during imem stall: br_taken=1 with imem_stall=1 -> pc_en=1, ifid_flush=1. imem_stall alone for 4 cycles -> pc_en=0, ifid_flush=1 each cycle, stall_cnt=4.
- Data stall over load-use: dmem_stall=1 for 3 cycles with lu=1 -> all enables 0. Then lu bubble one cycle; stall_cnt=4.
- Halt: halt_id=1 -> DRAIN for 3 cycles. Insert dmem_stall in the 2nd cycle -> drain extends to 4 cycles, then halted=1 and all enables 0 until rst=0.
- Saturation: force 70000 stall cycles with CNT_W=16 -> stall_cnt holds 16'hFFFF.
